stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 The block SHALL have the parameter DEBOUNCE_CYCLES, default 1_000_000, giving the number of stable cycles (20 ms at 50 MHz) needed to accept a button level.
REQ-003 The block SHALL have these ports, in this order:
- clk  in  1  50 MHz clock
- rst  in  1  synchronous active-high reset
- key_start_n  in  1  raw start/stop button, active-low, asynchronous
- key_lap_n  in  1  raw lap button, active-low, asynchronous
- key_clear_n  in  1  raw clear button, active-low, asynchronous
- max_reached  in  1  counter is at 59.999, i.e. digits 5,9,9,9,9
- count_en  out  1  count enable to the time counter
- counter_clr  out  1  one-cycle synchronous clear pulse to the time counter
- lap_hold  out  1  freeze the display latch
- state_o  out  3  current state encoding, for LEDs

Function
REQ-004 Each key SHALL pass through a 2-flop synchronizer, then a debouncer.
- The debouncer's stable counter restarts on any change of the synchronized level.
- The debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
REQ-005 Each debouncer SHALL emit a one-cycle press event when its debounced level goes released->pressed.
- The event asserts DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw level.
- Release and bounce SHALL produce no event.
REQ-006 The FSM SHALL have the states IDLE=0, RUNNING=1, PAUSED=2, LAP=3, DONE=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-007 The FSM SHALL make these transitions, with all other events ignored:
- IDLE: start -> RUNNING; clear -> IDLE with a counter_clr pulse.
- RUNNING: max_reached -> DONE; start -> PAUSED; lap -> LAP.
- LAP: max_reached -> DONE; start -> PAUSED; lap -> RUNNING.
- PAUSED: start -> RUNNING; clear -> IDLE with a counter_clr pulse.
- DONE: clear -> IDLE with a counter_clr pulse; start and lap ignored.
REQ-008 Simultaneous events SHALL resolve by priority max_reached > clear > start > lap; only the highest applicable event acts, and lower events in the same cycle are discarded.
REQ-009 Clear SHALL be ignored in RUNNING and LAP.
REQ-010 All outputs SHALL be registered:
- count_en=1 exactly in RUNNING or LAP.
- lap_hold=1 exactly in LAP.
- state_o equals the state register.
REQ-011 counter_clr SHALL be high for exactly one cycle, on the same edge the FSM enters IDLE via clear.
REQ-012 An event present at edge N SHALL be reflected in the state and outputs after edge N+1; event-to-output latency is one cycle.
REQ-013 max_reached SHALL be acted on only in RUNNING or LAP.
REQ-014 Leaving LAP by any path SHALL deassert lap_hold on the same edge.

Reset
REQ-015 With rst high at an edge, the block SHALL set:
- state IDLE, count_en=0, counter_clr=0, lap_hold=0, state_o=0;
- synchronizers and debounced levels to released (1);
- debounce counters to 0;
- no pending events.
REQ-016 Reset asserted mid-debounce or in any state SHALL discard the in-progress press; the first event after reset requires a full new debounce.
REQ-017 Reset SHALL NOT itself pulse counter_clr; the time counter is reset from the same reset source.

Structure
REQ-018 The shared package stopwatch_pkg SHALL hold:
- the state enumeration and its 3-bit width;
- the DEBOUNCE_CYCLES default;
- the clear-priority ordering constant.
REQ-019 The sub-module button_debounce SHALL contain synchronizer, stable counter, debounced level and press-event logic, parameterized by DEBOUNCE_CYCLES, and be instantiated three times.
REQ-020 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and the counter SHALL saturate without wrapping.

Verification (DEBOUNCE_CYCLES=4)
REQ-021 The bench SHALL run these directed scenarios:
- Start press, key_start_n low for 20 cycles -> event 6 edges after the first sampled low; count_en=1, state_o=1 one edge later.
- Key bounce low/high every 2 cycles for 12 cycles, then stable high -> no event; state stays IDLE.
- RUNNING, lap press -> lap_hold=1, count_en=1, state_o=3; second lap -> lap_hold=0, state_o=1.
- RUNNING, max_reached=1 on the same edge as a start event -> state DONE, count_en=0; a later start is ignored; clear -> counter_clr pulse one cycle, state IDLE.
- PAUSED, clear and start events on the same edge -> IDLE with counter_clr=1 for one cycle; RUNNING is not entered.
- LAP, rst high for one cycle -> next edge all outputs 0 and state IDLE; a key held low across reset yields its event only 6 edges after rst falls.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

  localparam int STATE_W                 = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Controller states; the encoding is driven straight onto the LEDs.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_LAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Event ordering: a larger code wins when several events share a cycle
  // (max_reached > clear > start > lap).
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_LAP   = 3'd1,
    EV_START = 3'd2,
    EV_CLEAR = 3'd3,
    EV_MAX   = 3'd4
  } event_e;

  // Select the single highest-ranked event among those applicable this cycle.
  function automatic event_e pick_event(input logic max_req, input logic clr_req,
                                        input logic start_req, input logic lap_req);
    if (max_req)        return EV_MAX;
    else if (clr_req)   return EV_CLEAR;
    else if (start_req) return EV_START;
    else if (lap_req)   return EV_LAP;
    else                return EV_NONE;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizer + debouncer for one active-low push button; emits a
// one-cycle press event when the debounced level goes released->pressed.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the asynchronous key input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that differ from the accepted level; any
  // return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Falling edge of the debounced level (released->pressed) gives the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounces three keys and sequences the time counter
// through idle/running/paused/lap/done with registered control outputs.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start_n,
  input  logic               key_lap_n,
  input  logic               key_clear_n,
  input  logic               max_reached,
  output logic               count_en,
  output logic               counter_clr,
  output logic               lap_hold,
  output logic [STATE_W-1:0] state_o
);

  logic   start_ev;
  logic   lap_ev;
  logic   clear_ev;
  state_e state_q;
  state_e state_d;
  logic   clr_d;
  event_e ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .key_n(key_start_n), .press(start_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .key_n(key_lap_n), .press(lap_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .key_n(key_clear_n), .press(clear_ev)
  );

  // Next-state logic: mask events not meaningful in the current state, then
  // act on only the highest-ranked remaining one.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    ev      = EV_NONE;
    case (state_q)
      ST_IDLE: begin
        ev = pick_event(1'b0, clear_ev, start_ev, 1'b0);
        if (ev == EV_START)      state_d = ST_RUNNING;
        else if (ev == EV_CLEAR) clr_d   = 1'b1;
      end
      ST_RUNNING: begin
        ev = pick_event(max_reached, 1'b0, start_ev, lap_ev);
        if (ev == EV_MAX)        state_d = ST_DONE;
        else if (ev == EV_START) state_d = ST_PAUSED;
        else if (ev == EV_LAP)   state_d = ST_LAP;
      end
      ST_LAP: begin
        ev = pick_event(max_reached, 1'b0, start_ev, lap_ev);
        if (ev == EV_MAX)        state_d = ST_DONE;
        else if (ev == EV_START) state_d = ST_PAUSED;
        else if (ev == EV_LAP)   state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        ev = pick_event(1'b0, clear_ev, start_ev, 1'b0);
        if (ev == EV_CLEAR) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (ev == EV_START) begin
          state_d = ST_RUNNING;
        end
      end
      ST_DONE: begin
        ev = pick_event(1'b0, clear_ev, 1'b0, 1'b0);
        if (ev == EV_CLEAR) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with outputs registered from the next state, so they
  // change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_en    <= 1'b0;
      lap_hold    <= 1'b0;
      counter_clr <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_en    <= (state_d == ST_RUNNING) || (state_d == ST_LAP);
      lap_hold    <= (state_d == ST_LAP);
      counter_clr <= clr_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       key_start_n;
  logic       key_lap_n;
  logic       key_clear_n;
  logic       max_reached;
  logic       count_en;
  logic       counter_clr;
  logic       lap_hold;
  logic [2:0] state_o;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  // Expected {state_o, count_en, lap_hold, counter_clr}
  localparam logic [5:0] O_IDLE    = 6'b000_000;
  localparam logic [5:0] O_IDLECLR = 6'b000_001;
  localparam logic [5:0] O_RUN     = 6'b001_100;
  localparam logic [5:0] O_PAUSED  = 6'b010_000;
  localparam logic [5:0] O_LAP     = 6'b011_110;
  localparam logic [5:0] O_DONE    = 6'b100_000;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .key_start_n(key_start_n), .key_lap_n(key_lap_n), .key_clear_n(key_clear_n),
    .max_reached(max_reached),
    .count_en(count_en), .counter_clr(counter_clr), .lap_hold(lap_hold),
    .state_o(state_o)
  );

  assign obs = {state_o, count_en, lap_hold, counter_clr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release all keys and wait long enough for the debouncers to settle.
  task automatic release_keys();
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    key_clear_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, O_IDLE);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      key_start_n = 1'b0; tick(2);
      key_start_n = 1'b1; tick(2);
    end
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL bounce_mid: got %b expected %b", obs, O_IDLE);
    end
    release_keys();
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL bounce_settled: got %b expected %b", obs, O_IDLE);
    end
  endtask

  task automatic test_start();
    key_start_n = 1'b0;
    tick(7);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL start_too_early: got %b expected %b", obs, O_IDLE);
    end
    tick(1);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL start_run: got %b expected %b", obs, O_RUN);
    end
    tick(12);
    release_keys();
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL start_release: got %b expected %b", obs, O_RUN);
    end
  endtask

  task automatic test_lap();
    key_lap_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_LAP) begin
      errors++; $display("FAIL lap_enter: got %b expected %b", obs, O_LAP);
    end
    release_keys();
    checks++;
    if (obs !== O_LAP) begin
      errors++; $display("FAIL lap_release: got %b expected %b", obs, O_LAP);
    end
    key_lap_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL lap_exit: got %b expected %b", obs, O_RUN);
    end
    release_keys();
  endtask

  task automatic test_max_done();
    key_start_n = 1'b0;
    tick(7);
    max_reached = 1'b1;
    tick(1);
    max_reached = 1'b0;
    checks++;
    if (obs !== O_DONE) begin
      errors++; $display("FAIL max_over_start: got %b expected %b", obs, O_DONE);
    end
    release_keys();
    key_start_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_DONE) begin
      errors++; $display("FAIL done_ignores_start: got %b expected %b", obs, O_DONE);
    end
    release_keys();
    key_clear_n = 1'b0;
    tick(7);
    checks++;
    if (obs !== O_DONE) begin
      errors++; $display("FAIL done_clear_early: got %b expected %b", obs, O_DONE);
    end
    tick(1);
    checks++;
    if (obs !== O_IDLECLR) begin
      errors++; $display("FAIL done_clear_pulse: got %b expected %b", obs, O_IDLECLR);
    end
    tick(1);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL done_clear_one_cycle: got %b expected %b", obs, O_IDLE);
    end
    release_keys();
  endtask

  task automatic test_paused_clear_start();
    key_start_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL pause_setup_run: got %b expected %b", obs, O_RUN);
    end
    release_keys();
    key_start_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_PAUSED) begin
      errors++; $display("FAIL pause_enter: got %b expected %b", obs, O_PAUSED);
    end
    release_keys();
    max_reached = 1'b1;
    tick(3);
    max_reached = 1'b0;
    checks++;
    if (obs !== O_PAUSED) begin
      errors++; $display("FAIL paused_ignores_max: got %b expected %b", obs, O_PAUSED);
    end
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_IDLECLR) begin
      errors++; $display("FAIL clear_over_start: got %b expected %b", obs, O_IDLECLR);
    end
    tick(1);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL clear_over_start_after: got %b expected %b", obs, O_IDLE);
    end
    release_keys();
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL clear_over_start_settled: got %b expected %b", obs, O_IDLE);
    end
  endtask

  task automatic test_reset_in_lap();
    key_start_n = 1'b0;
    tick(8);
    release_keys();
    key_lap_n = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_LAP) begin
      errors++; $display("FAIL rst_setup_lap: got %b expected %b", obs, O_LAP);
    end
    release_keys();
    key_start_n = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL rst_in_lap: got %b expected %b", obs, O_IDLE);
    end
    rst = 1'b0;
    tick(7);
    checks++;
    if (obs !== O_IDLE) begin
      errors++; $display("FAIL rst_discards_press: got %b expected %b", obs, O_IDLE);
    end
    tick(1);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL rst_full_debounce: got %b expected %b", obs, O_RUN);
    end
    release_keys();
  endtask

  initial begin
    rst         = 1'b1;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    key_clear_n = 1'b1;
    max_reached = 1'b0;
    test_reset();
    test_bounce();
    test_start();
    test_lap();
    test_max_done();
    test_paused_clear_start();
    test_reset_in_lap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
